// File: rtl/spi_link_arbiter_if.sv
// Bundle of requester-side and SPI-link-side signals shared between the
// arbiter (slave modport) and its clients/link (master modport).
interface spi_link_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 11
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    grant;
  logic               new_d;
  logic [DW-1:0]      d_out;
  logic               xfer_done;
  logic [DW-1:0]      rx_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               busy;

  modport slave (
    input  req, req_data, xfer_done, rx_data,
    output grant, new_d, d_out, rsp_valid, rsp_data, rsp_err, busy
  );

  modport master (
    output req, req_data, xfer_done, rx_data,
    input  grant, new_d, d_out, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/spi_link_arbiter.sv
// Round-robin sequencer sharing one SPI link: picks a requester, launches its
// word with a one-cycle new_d, waits for the slave done edge, returns the result.
module spi_link_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 11,
  parameter int TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst,
  spi_link_arbiter_if.slave io_link
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_last;
  logic [IW-1:0]   r_id;
  logic [TW-1:0]   r_timer;
  logic            r_done_q;
  logic [NREQ-1:0] r_grant;
  logic            r_new_d;
  logic [DW-1:0]   r_d_out;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic            r_rsp_err;
  logic            r_busy;

  logic            w_done_rise;
  logic [IW-1:0]   w_sel_idx;
  logic [IW-1:0]   w_cand;
  logic [DW-1:0]   w_words [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_word
      assign w_words[gi] = io_link.req_data[gi*DW +: DW];
    end
  endgenerate

  // A done level still high from the previous transfer must not retrigger.
  assign w_done_rise = io_link.xfer_done & ~r_done_q;

  // Scan from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    w_sel_idx = '0;
    w_cand    = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(r_last) + k) % NREQ);
      if (io_link.req[w_cand]) begin
        w_sel_idx = w_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_id        <= '0;
      r_timer     <= '0;
      r_done_q    <= 1'b0;
      r_grant     <= '0;
      r_new_d     <= 1'b0;
      r_d_out     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done_q <= io_link.xfer_done;
      case (r_state)
        S_IDLE: begin
          if (|io_link.req) begin
            r_id    <= w_sel_idx;
            r_d_out <= w_words[w_sel_idx];
            r_grant <= NREQ'(1) << w_sel_idx;
            r_new_d <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_grant <= '0;
          r_new_d <= 1'b0;
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_done_rise) begin
            r_rsp_data  <= io_link.rx_data;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= NREQ'(1) << r_id;
            r_state     <= S_RESP;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= NREQ'(1) << r_id;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
          r_last      <= r_id;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_link.grant     = r_grant;
  assign io_link.new_d     = r_new_d;
  assign io_link.d_out     = r_d_out;
  assign io_link.rsp_valid = r_rsp_valid;
  assign io_link.rsp_data  = r_rsp_data;
  assign io_link.rsp_err   = r_rsp_err;
  assign io_link.busy      = r_busy;
endmodule

// File: tb/tb_spi_link_arbiter.sv
// Directed scoreboard bench: stimulus pushes expected grants/responses,
// a negedge monitor pops and compares whenever the arbiter presents them.
module tb_spi_link_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 11;
  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [NREQ-1:0] oh;
    logic [DW-1:0]   data;
    logic            err;
    int              lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_link_arbiter_if #(.NREQ(NREQ), .DW(DW)) link ();

  spi_link_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .io_link (link)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   launch_cyc = 0;
  bit   prev_rsp = 1'b0;
  exp_t gq[$];
  exp_t rq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("check %s ok: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push_grant(input logic [NREQ-1:0] oh, input logic [DW-1:0] d);
    exp_t e;
    e.oh = oh; e.data = d; e.err = 1'b0; e.lat = 0;
    gq.push_back(e);
  endtask

  task automatic push_rsp(input logic [NREQ-1:0] oh, input logic [DW-1:0] d,
                          input logic err, input int lat);
    exp_t e;
    e.oh = oh; e.data = d; e.err = err; e.lat = lat;
    rq.push_back(e);
  endtask

  // Monitor: one line per observed grant or response transaction.
  always @(negedge clk) begin
    exp_t e;
    if (prev_rsp) chk("busy_after_rsp", {31'b0, link.busy}, 32'd0);
    if (link.new_d === 1'b1 || (link.grant !== '0 && !$isunknown(link.grant))) begin
      launch_cyc = cyc;
      if (gq.size() == 0) begin
        checks++; errors++;
        $display("FAIL grant_unexpected: grant=%b new_d=%b, expected none", link.grant, link.new_d);
      end else begin
        e = gq.pop_front();
        chk("grant", {28'b0, link.grant}, {28'b0, e.oh});
        chk("new_d", {31'b0, link.new_d}, 32'd1);
        chk("d_out", {21'b0, link.d_out}, {21'b0, e.data});
      end
    end
    if (link.rsp_valid !== '0 && !$isunknown(link.rsp_valid)) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b, expected none", link.rsp_valid);
      end else begin
        e = rq.pop_front();
        chk("rsp_valid", {28'b0, link.rsp_valid}, {28'b0, e.oh});
        chk("rsp_data", {21'b0, link.rsp_data}, {21'b0, e.data});
        chk("rsp_err", {31'b0, link.rsp_err}, {31'b0, e.err});
        chk("busy_in_resp", {31'b0, link.busy}, 32'd1);
        chk("launch_to_rsp_cycles", cyc - launch_cyc, e.lat);
      end
      prev_rsp = 1'b1;
    end else begin
      prev_rsp = 1'b0;
    end
  end

  task automatic set_word(input int i, input logic [DW-1:0] w);
    link.req_data[i*DW +: DW] = w;
  endtask

  task automatic wait_launch(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < 60 && !ok) begin
      @(negedge clk);
      n++;
      if (link.new_d === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL launch_timeout: no new_d within %0d cycles, expected a launch", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 60 && !ok) begin
      @(negedge clk);
      n++;
      if (link.busy === 1'b0) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles, expected 0", link.busy, n);
    end
  endtask

  // Slave model: d<0 never answers; d>=0 pulses done d cycles after the launch cycle.
  task automatic serve(input int d, input logic [DW-1:0] rx, input logic [NREQ-1:0] nreq,
                       input bit hold, input int exp_wait);
    int n;
    bit ok;
    wait_launch(n, ok);
    if (!ok) return;
    if (exp_wait != 0) chk("req_to_grant_cycles", n, exp_wait);
    if (d <= 0) link.req = nreq;
    for (int i = 0; i < d; i++) begin
      @(posedge clk); #1;
      if (i == 0) link.req = nreq;
    end
    if (d >= 0) begin
      link.rx_data   = rx;
      link.xfer_done = 1'b1;
      @(posedge clk); #1;
      link.xfer_done = hold;
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"},     {28'b0, link.grant},     32'd0);
    chk({tag, "_new_d"},     {31'b0, link.new_d},     32'd0);
    chk({tag, "_d_out"},     {21'b0, link.d_out},     32'd0);
    chk({tag, "_rsp_valid"}, {28'b0, link.rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"},  {21'b0, link.rsp_data},  32'd0);
    chk({tag, "_rsp_err"},   {31'b0, link.rsp_err},   32'd0);
    chk({tag, "_busy"},      {31'b0, link.busy},      32'd0);
  endtask

  initial begin
    int n;
    bit ok;
    link.req       = '0;
    link.req_data  = '0;
    link.xfer_done = 1'b0;
    link.rx_data   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_quiet("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention straight out of reset: 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_word(i, DW'(11'h100 + i));
    link.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_grant(4'b0001 << (k % 4), DW'(11'h100 + (k % 4)));
      push_rsp(4'b0001 << (k % 4), DW'(11'h200 + k), 1'b0, 4);
    end
    for (int k = 0; k < 5; k++) begin
      serve(3, DW'(11'h200 + k), (k == 4) ? 4'b0000 : 4'b1111, 1'b0, 0);
      wait_idle();
    end

    // Single request from requester 2
    @(posedge clk); #1;
    set_word(0, 11'h111);
    set_word(2, 11'h5A3);
    link.req = 4'b0100;
    push_grant(4'b0100, 11'h5A3);
    push_rsp(4'b0100, 11'h5A3, 1'b0, 13);
    serve(12, 11'h5A3, 4'b0000, 1'b0, 2);
    wait_idle();

    // Round-robin resume after requester 2: wraps to 0, then 2
    @(posedge clk); #1;
    set_word(0, 11'h7F0); set_word(1, 11'h0AA); set_word(2, 11'h3C3); set_word(3, 11'h555);
    link.req = 4'b0101;
    push_grant(4'b0001, 11'h7F0);
    push_rsp(4'b0001, 11'h0B1, 1'b0, 3);
    push_grant(4'b0100, 11'h3C3);
    push_rsp(4'b0100, 11'h0B2, 1'b0, 3);
    serve(2, 11'h0B1, 4'b0100, 1'b0, 0);
    wait_idle();
    serve(2, 11'h0B2, 4'b0000, 1'b0, 0);
    wait_idle();

    // Timeout: done never arrives
    @(posedge clk); #1;
    set_word(3, 11'h7FF);
    link.req = 4'b1000;
    push_grant(4'b1000, 11'h7FF);
    push_rsp(4'b1000, 11'h000, 1'b1, TIMEOUT + 1);
    serve(-1, 11'h000, 4'b0000, 1'b0, 0);
    wait_idle();

    // Done on the terminal timer count wins over timeout
    @(posedge clk); #1;
    set_word(1, 11'h321);
    link.req = 4'b0010;
    push_grant(4'b0010, 11'h321);
    push_rsp(4'b0010, 11'h0F0, 1'b0, TIMEOUT + 1);
    serve(TIMEOUT, 11'h0F0, 4'b0000, 1'b0, 0);
    wait_idle();

    // Done edge inside LAUNCH is ignored, transfer times out
    @(posedge clk); #1;
    set_word(0, 11'h0F1);
    link.req = 4'b0001;
    push_grant(4'b0001, 11'h0F1);
    push_rsp(4'b0001, 11'h000, 1'b1, TIMEOUT + 1);
    serve(0, 11'h7E7, 4'b0000, 1'b0, 0);
    wait_idle();

    // Stale done level held into the next transfer
    @(posedge clk); #1;
    set_word(0, 11'h444);
    link.req = 4'b0001;
    push_grant(4'b0001, 11'h444);
    push_rsp(4'b0001, 11'h1AB, 1'b0, 3);
    serve(2, 11'h1AB, 4'b0000, 1'b1, 0);
    wait_idle();
    @(posedge clk); #1;
    set_word(1, 11'h222);
    link.req = 4'b0010;
    push_grant(4'b0010, 11'h222);
    push_rsp(4'b0010, 11'h333, 1'b0, 8);
    wait_launch(n, ok);
    if (ok) begin
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (i == 0) link.req = 4'b0000;
      end
      link.xfer_done = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      link.rx_data   = 11'h333;
      link.xfer_done = 1'b1;
      @(posedge clk); #1;
      link.xfer_done = 1'b0;
    end
    wait_idle();

    // Reset mid-WAIT drops the transfer and restores the pointer
    @(posedge clk); #1;
    set_word(2, 11'h0CC);
    link.req = 4'b0100;
    push_grant(4'b0100, 11'h0CC);
    wait_launch(n, ok);
    repeat (3) begin @(posedge clk); #1; end
    push_grant(4'b0010, 11'h155);
    push_rsp(4'b0010, 11'h011, 1'b0, 5);
    push_grant(4'b0100, 11'h2AA);
    push_rsp(4'b0100, 11'h022, 1'b0, 5);
    rst = 1'b1;
    set_word(1, 11'h155);
    set_word(2, 11'h2AA);
    link.req = 4'b0110;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_quiet("after_rst");
    serve(4, 11'h011, 4'b0100, 1'b0, 0);
    wait_idle();
    serve(4, 11'h022, 4'b0000, 1'b0, 0);
    wait_idle();

    repeat (5) @(posedge clk);
    chk("pending_grants", gq.size(), 32'd0);
    chk("pending_rsps", rq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
